// File: rtl/serial_parity_checker.sv
// Serial LSB-first frame receiver: DATA_W data bits plus a parity bit, with an even/odd check (ODD) and a saturating error count.
// Latency: all outputs registered; pulses appear one cycle after the sampling edge. No backpressure: x_valid is a strobe and every valid bit is consumed.
// Optional SERIAL_PARITY_STICKY_ERR_EN adds err_sticky; otherwise err_sticky is tied low.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    input  logic              x_valid,
    input  logic              sof,
    input  logic              clr_count,
    output logic              z,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_err,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr;
    logic              bad;

    // Parity bit accepted this cycle and it disagrees with the running XOR
    assign bad = x_valid && !sof && (state == PARITY) && (x != (z ^ ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            z           <= 1'b0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
            if (x_valid) begin
                if (sof) begin
                    // sof always opens a fresh frame; mid-frame it discards the partial one
                    if (state != IDLE) frame_abort <= 1'b1;
                    sr    <= {x, sr[DATA_W-1:1]};
                    z     <= x;
                    cnt   <= CW'(1);
                    state <= DATA;
                end else begin
                    case (state)
                        IDLE: begin
                        end
                        DATA: begin
                            sr  <= {x, sr[DATA_W-1:1]};
                            z   <= z ^ x;
                            cnt <= cnt + CW'(1);
                            if (cnt == CW'(DATA_W - 1)) state <= PARITY;
                        end
                        PARITY: begin
                            data_out   <= sr;
                            frame_done <= 1'b1;
                            parity_err <= bad;
                            z          <= 1'b0;
                            cnt        <= '0;
                            state      <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // Clear wins, but an error in the same cycle still counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= CNT_W'(bad);
        end else if (bad && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

`ifdef SERIAL_PARITY_STICKY_ERR_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (clr_count) begin
            sticky_q <= bad;
        end else if (bad) begin
            sticky_q <= 1'b1;
        end
    end

    assign err_sticky = sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-parity/8-bit-count instance and an odd-parity/2-bit-count instance share one stimulus stream.
// Expected frame results are queued at the parity bit and popped by a monitor on each frame_done.
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0, x_valid = 1'b0, sof = 1'b0, clr_count = 1'b0;

    logic       e_z, e_done, e_perr, e_abort, e_sticky;
    logic [7:0] e_data, e_cnt;
    logic       o_z, o_done, o_perr, o_abort, o_sticky;
    logic [7:0] o_data;
    logic [1:0] o_cnt;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(8), .ODD(1'b0), .CNT_W(8)) dut_e (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof), .clr_count(clr_count),
        .z(e_z), .data_out(e_data), .frame_done(e_done), .parity_err(e_perr),
        .frame_abort(e_abort), .err_count(e_cnt), .err_sticky(e_sticky));

    serial_parity_checker #(.DATA_W(8), .ODD(1'b1), .CNT_W(2)) dut_o (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof), .clr_count(clr_count),
        .z(o_z), .data_out(o_data), .frame_done(o_done), .parity_err(o_perr),
        .frame_abort(o_abort), .err_count(o_cnt), .err_sticky(o_sticky));

    typedef struct packed {
        logic [7:0] d;
        logic       e;
        logic [7:0] c;
        logic       s;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];

    int checks = 0;
    int errors = 0;
    int cnt_e = 0, cnt_o = 0;
    logic stk_e = 1'b0, stk_o = 1'b0;
    int abort_exp = 0;
    int abort_seen_e = 0, abort_seen_o = 0;
    int cyc = 0, prev_done = 0, last_done = 0;
    logic [7:0] last_data_e = 8'h00, last_data_o = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            x_valid = 1'b0; sof = 1'b0; clr_count = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic clr);
        exp_t t;
        logic err_e, err_o;
        err_e = p ^ (^d);
        err_o = ~err_e;
        cnt_e = clr ? int'(err_e) : ((cnt_e == 255) ? 255 : cnt_e + int'(err_e));
        cnt_o = clr ? int'(err_o) : ((cnt_o == 3) ? 3 : cnt_o + int'(err_o));
        stk_e = clr ? err_e : (stk_e | err_e);
        stk_o = clr ? err_o : (stk_o | err_o);
        t.d = d; t.e = err_e; t.c = 8'(cnt_e);
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        t.s = stk_e;
`else
        t.s = 1'b0;
`endif
        q_e.push_back(t);
        t.e = err_o; t.c = 8'(cnt_o);
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        t.s = stk_o;
`else
        t.s = 1'b0;
`endif
        q_o.push_back(t);
    endtask

    // gap_at: bit index before which x_valid drops for gap_len cycles (use >7 for none)
    task automatic send_frame(input logic [7:0] d, input logic p, input int gap_at,
                              input int gap_len, input logic clr, input logic chkz);
        logic zx;
        zx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) idle(gap_len);
            @(negedge clk);
            if (chkz && i > 0) chk("z_trace", e_z, zx);
            x = d[i]; x_valid = 1'b1; sof = (i == 0); clr_count = 1'b0;
            zx ^= d[i];
        end
        @(negedge clk);
        if (chkz) chk("z_before_parity", e_z, zx);
        x = p; x_valid = 1'b1; sof = 1'b0; clr_count = clr;
        push_exp(d, p, clr);
    endtask

    task automatic clear_only();
        @(negedge clk);
        x_valid = 1'b0; sof = 1'b0; clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        cnt_e = 0; cnt_o = 0; stk_e = 1'b0; stk_o = 1'b0;
        chk("clr_cnt_e", e_cnt, 0);
        chk("clr_cnt_o", o_cnt, 0);
        chk("clr_sticky_o", o_sticky, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t t;
        cyc++;
        if (!rst_n) begin
            last_data_e = 8'h00;
            last_data_o = 8'h00;
        end
        if (e_done) begin
            if (q_e.size() == 0) chk("e_unexpected_done", 1, 0);
            else begin
                t = q_e.pop_front();
                chk("e_data", e_data, t.d);
                chk("e_perr", e_perr, t.e);
                chk("e_cnt", e_cnt, t.c);
                chk("e_sticky", e_sticky, t.s);
                chk("e_z_after", e_z, 0);
                last_data_e = t.d;
            end
            prev_done = last_done;
            last_done = cyc;
        end else if (e_perr) chk("e_perr_without_done", 1, 0);
        if (o_done) begin
            if (q_o.size() == 0) chk("o_unexpected_done", 1, 0);
            else begin
                t = q_o.pop_front();
                chk("o_data", o_data, t.d);
                chk("o_perr", o_perr, t.e);
                chk("o_cnt", o_cnt, t.c);
                chk("o_sticky", o_sticky, t.s);
                last_data_o = t.d;
            end
        end else if (o_perr) chk("o_perr_without_done", 1, 0);
        if (e_abort) begin
            abort_seen_e++;
            chk("e_abort_data_hold", e_data, last_data_e);
        end
        if (o_abort) begin
            abort_seen_o++;
            chk("o_abort_data_hold", o_data, last_data_o);
        end
    end

    initial begin
        #12;
        chk("rst_e_outputs", {e_z, e_data, e_done, e_perr, e_abort, e_cnt, e_sticky}, 0);
        chk("rst_o_outputs", {o_z, o_data, o_done, o_perr, o_abort, o_cnt, o_sticky}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 0xA5 parity 0: good for even, bad for odd
        send_frame(8'hA5, 1'b0, 99, 0, 1'b0, 1'b1);
        idle(2);
        chk("a5_data", e_data, 8'hA5);
        chk("a5_even_cnt", e_cnt, 0);
        chk("a5_odd_cnt", o_cnt, 1);
        // 0xA5 parity 1: bad for even, good for odd
        send_frame(8'hA5, 1'b1, 99, 0, 1'b0, 1'b0);
        idle(2);
        chk("a5p1_odd_cnt", o_cnt, 1);
        clear_only();

        // Abort after 4 bits, then full 0x3C frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = 1'b1; x_valid = 1'b1; sof = (i == 0); clr_count = 1'b0;
        end
        abort_exp++;
        send_frame(8'h3C, 1'b0, 99, 0, 1'b0, 1'b0);
        idle(2);
        chk("abort_then_3c", e_data, 8'h3C);

        // 3-cycle gap mid-frame
        send_frame(8'h5A, 1'b0, 4, 3, 1'b0, 1'b1);
        idle(2);
        chk("gap_data", e_data, 8'h5A);

        // Back-to-back frames
        send_frame(8'h81, 1'b0, 99, 0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 99, 0, 1'b0, 1'b0);
        idle(2);
        chk("b2b_spacing", last_done - prev_done, 9);

        // Saturation of the 2-bit counter
        clear_only();
        for (int k = 1; k <= 5; k++) begin
            logic [7:0] d;
            d = 8'(k);
            send_frame(d, ^d, 99, 0, 1'b0, 1'b0);
        end
        idle(2);
        chk("sat_cnt", o_cnt, 3);
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        chk("sat_sticky", o_sticky, 1);
`else
        chk("sat_sticky", o_sticky, 0);
`endif
        send_frame(8'h0F, 1'b0, 99, 0, 1'b1, 1'b0);
        idle(2);
        chk("clr_with_err_cnt", o_cnt, 1);
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        chk("clr_with_err_sticky", o_sticky, 1);
`else
        chk("clr_with_err_sticky", o_sticky, 0);
`endif

        // Async reset after bit 4 of a frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x = i[0]; x_valid = 1'b1; sof = (i == 0); clr_count = 1'b0;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_e_outputs", {e_z, e_data, e_done, e_perr, e_abort, e_cnt, e_sticky}, 0);
        chk("midrst_o_outputs", {o_z, o_data, o_done, o_perr, o_abort, o_cnt, o_sticky}, 0);
        cnt_e = 0; cnt_o = 0; stk_e = 1'b0; stk_o = 1'b0;
        @(negedge clk);
        x_valid = 1'b0; sof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hC3, 1'b0, 99, 0, 1'b0, 1'b1);
        idle(3);
        chk("post_rst_data", e_data, 8'hC3);
        chk("post_rst_odd_cnt", o_cnt, 1);

        chk("q_e_drained", q_e.size(), 0);
        chk("q_o_drained", q_o.size(), 0);
        chk("abort_count_e", abort_seen_e, abort_exp);
        chk("abort_count_o", abort_seen_o, abort_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
